// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle unsigned adder. Two WIDTH-bit operands and a carry-in are
//   captured through a valid/ready handshake. The sum is then formed CHUNK
//   bits per clock, with the carry held in a register between chunks. The
//   result is presented through a second valid/ready handshake.
//
//   Optional feature macro: SEQ_CHUNK_ADDER_SUB_EN
//     When defined, the sub_i input exists and is captured with the operands.
//     sub_i=1 computes a_i-b_i mod 2^WIDTH. In that mode c_o=1 means no borrow.
//     When undefined, the block only adds.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous active-high reset
//   valid_i  in   operand request
//   ready_o  out  operands can be accepted (IDLE and not in reset)
//   a_i      in   [WIDTH] operand A
//   b_i      in   [WIDTH] operand B
//   c_i      in   carry-in
//   sub_i    in   subtract select (only with SEQ_CHUNK_ADDER_SUB_EN)
//   valid_o  out  result available (DONE)
//   ready_i  in   downstream accepts result
//   s_o      out  [WIDTH] sum
//   c_o      out  carry-out
//   busy_o   out  operation in progress (CALC or DONE)
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             busy_o
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $fatal(1, "seq_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic              r_co;

  logic [WIDTH-1:0]  w_b_in;
  logic              w_c_in;
  logic              w_accept;
  logic              w_last;
  logic [CHUNK-1:0]  w_a_sel;
  logic [CHUNK-1:0]  w_b_sel;
  logic [CHUNK:0]    w_sum;
  logic [CHUNK-1:0]  w_a_ch [NCHUNK];
  logic [CHUNK-1:0]  w_b_ch [NCHUNK];

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  // Subtraction is done as a + ~b + 1, so the datapath stays a plain adder.
  assign w_b_in = sub_i ? ~b_i : b_i;
  assign w_c_in = sub_i | c_i;
`else
  assign w_b_in = b_i;
  assign w_c_in = c_i;
`endif

  assign w_accept = (r_state == ST_IDLE) && valid_i;
  assign w_last   = (r_idx == IDXW'(NCHUNK - 1));

  // Split the captured operands into chunk slices.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_split
    assign w_a_ch[gi] = r_a[gi*CHUNK +: CHUNK];
    assign w_b_ch[gi] = r_b[gi*CHUNK +: CHUNK];
  end

  // Select the current chunk. Index values with no matching chunk are never
  // reached; for those the select defaults to zero.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_sel = w_a_ch[i];
        w_b_sel = w_b_ch[i];
      end
    end
  end

  assign w_sum = {1'b0, w_a_sel} + {1'b0, w_b_sel} + {{CHUNK{1'b0}}, r_carry};

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = ~rst_i;
        if (valid_i) w_state_next = ST_CALC;
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        if (ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_co    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= a_i;
        r_b     <= w_b_in;
        r_carry <= w_c_in;
        r_idx   <= '0;
      end else if (r_state == ST_CALC) begin
        r_carry <= w_sum[CHUNK];
        r_idx   <= r_idx + 1'b1;
        if (w_last) r_co <= w_sum[CHUNK];
      end
    end
  end

  // Each sum chunk has its own register. It is written only on the cycle that
  // processes that chunk, so s_o holds its value until a new operation
  // overwrites it.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    logic [CHUNK-1:0] r_s_chunk;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_s_chunk <= '0;
      end else if (r_state == ST_CALC && r_idx == IDXW'(gi)) begin
        r_s_chunk <= w_sum[CHUNK-1:0];
      end
    end
    assign s_o[gi*CHUNK +: CHUNK] = r_s_chunk;
  end

  assign c_o = r_co;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder
//   Testbench for seq_chunk_adder (WIDTH=16, CHUNK=4). The driver issues
//   operations and pushes the expected {sum, carry} into a queue. A separate
//   monitor pops and compares on every result handshake. The expected values
//   come from whole-word arithmetic. The driver also checks latency,
//   busy/ready, backpressure hold and reset abort.
//   Optional feature macro: SEQ_CHUNK_ADDER_SUB_EN (adds subtract cases).
module tb_seq_chunk_adder;
  localparam int W  = 16;
  localparam int CH = 4;
  localparam int NC = W / CH;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         c_i;
  logic         sub_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] s_o;
  logic         c_o;
  logic         busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } res_t;

  res_t exp_q[$];

  seq_chunk_adder #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub_i   (sub_i),
`endif
    .valid_o (valid_o),
    .ready_i (ready_i),
    .s_o     (s_o),
    .c_o     (c_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: whole-word arithmetic, no chunking.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic sub);
    res_t r;
    longint unsigned t;
    if (sub) begin
      r.s = W'(a - b);
      r.c = (a >= b);
    end else begin
      t   = longint'(a) + longint'(b) + longint'(c);
      r.s = t[W-1:0];
      r.c = t[W];
    end
    return r;
  endfunction

  // Monitor: compare on every result handshake.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk_eq("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk_eq("sum", 32'(s_o), 32'(e.s));
        chk_eq("carry", 32'(c_o), 32'(e.c));
      end
    end
  end

  // Present the operands and wait a bounded time for the accept edge.
  // The task returns at 1 time unit after the accept edge.
  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic sub, output bit ok);
    valid_i = 1'b1; a_i = a; b_i = b; c_i = c; sub_i = sub;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(negedge clk_i);
      ok = ready_o;
      @(posedge clk_i); #1;
    end
    chk_eq("accept", 32'(ok), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic sub, input int bp, input bit garble);
    bit   ok;
    res_t e;
    do_accept(a, b, c, sub, ok);
    if (!ok) begin
      valid_i = 1'b0;
      return;
    end
    e = model(a, b, c, sub);
    exp_q.push_back(e);
    $display("op a=%h b=%h c=%0d sub=%0d bp=%0d garble=%0d -> expect s=%h c=%0d",
             a, b, c, sub, bp, garble, e.s, e.c);
    valid_i = garble;
    ready_i = (bp == 0);
    for (int k = 1; k <= NC; k++) begin
      if (garble) begin
        a_i = W'($urandom); b_i = W'($urandom); c_i = 1'($urandom); sub_i = 1'($urandom);
      end
      @(posedge clk_i); #1;
      chk_eq("latency_valid", 32'(valid_o), 32'(k == NC));
      chk_eq("busy", 32'(busy_o), 32'd1);
      chk_eq("ready_while_busy", 32'(ready_o), 32'd0);
    end
    for (int k = 0; k < bp; k++) begin
      valid_i = 1'b1;
      a_i = W'($urandom); b_i = W'($urandom); c_i = 1'($urandom); sub_i = 1'($urandom);
      @(posedge clk_i); #1;
      chk_eq("bp_valid", 32'(valid_o), 32'd1);
      chk_eq("bp_ready", 32'(ready_o), 32'd0);
      chk_eq("bp_busy", 32'(busy_o), 32'd1);
      chk_eq("bp_sum_hold", 32'(s_o), 32'(e.s));
      chk_eq("bp_carry_hold", 32'(c_o), 32'(e.c));
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk_eq("idle_valid", 32'(valid_o), 32'd0);
    chk_eq("idle_ready", 32'(ready_o), 32'd1);
    chk_eq("idle_busy", 32'(busy_o), 32'd0);
    chk_eq("idle_sum_hold", 32'(s_o), 32'(e.s));
    valid_i = 1'b0;
  endtask

  // Accept an operation, then reset in its second CALC cycle.
  task automatic send_abort(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit ok;
    do_accept(a, b, c, 1'b0, ok);
    valid_i = 1'b0;
    $display("op a=%h b=%h c=%0d -> aborted by reset", a, b, c);
    @(posedge clk_i); #1;
    chk_eq("abort_valid_calc", 32'(valid_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk_eq("abort_valid", 32'(valid_o), 32'd0);
    chk_eq("abort_busy", 32'(busy_o), 32'd0);
    chk_eq("abort_ready_in_reset", 32'(ready_o), 32'd0);
    chk_eq("abort_sum", 32'(s_o), 32'd0);
    chk_eq("abort_carry", 32'(c_o), 32'd0);
    rst_i = 1'b0;
    for (int k = 0; k < NC + 2; k++) begin
      @(posedge clk_i); #1;
      chk_eq("abort_no_valid", 32'(valid_o), 32'd0);
      chk_eq("abort_idle_ready", 32'(ready_o), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    // Reset with valid_i asserted; nothing may be accepted.
    rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    a_i = 16'h1111; b_i = 16'h2222; c_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_eq("rst_valid", 32'(valid_o), 32'd0);
    chk_eq("rst_busy", 32'(busy_o), 32'd0);
    chk_eq("rst_ready", 32'(ready_o), 32'd0);
    chk_eq("rst_sum", 32'(s_o), 32'd0);
    chk_eq("rst_carry", 32'(c_o), 32'd0);
    rst_i = 1'b0; valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk_eq("post_rst_busy", 32'(busy_o), 32'd0);
    chk_eq("post_rst_ready", 32'(ready_o), 32'd1);

    send(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    send(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 5, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0, 1'b0, 0, 1'b0);
    send_abort(16'h5555, 16'hAAAA, 1'b1);
    send(16'h00F0, 16'h0010, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      send(ra, rb, 1'($urandom), 1'b0, 0, 1'b1);
    end
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
`endif
    for (int i = 0; i < 40; i++) begin
      logic sub;
      ra = W'($urandom); rb = W'($urandom);
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      send(ra, rb, 1'($urandom), sub, int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
